// File: rtl/fft_round_sat_if.sv
// Stream bundle for fft_round_sat: input sample channel and output channel,
// each with its own valid/ready pair.
interface fft_round_sat_if #(
    parameter int IN_W    = 15,
    parameter int OUT_W   = 14,
    parameter int SHIFT_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_re;
    logic [IN_W-1:0]    in_im;
    logic [SHIFT_W-1:0] shift_i;
    logic [1:0]         mode_i;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_re;
    logic [OUT_W-1:0]   out_im;
    logic               out_sat;

    modport slave (
        input  in_valid, in_re, in_im, shift_i, mode_i, out_ready,
        output in_ready, out_valid, out_re, out_im, out_sat
    );

    modport master (
        output in_valid, in_re, in_im, shift_i, mode_i, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_sat
    );
endinterface

// File: rtl/fft_round_sat.sv
// Two-stage round-and-saturate for complex FFT butterfly outputs.
// Define FFT_ROUND_SAT_CNT_EN to build the saturation event counter.
module fft_round_sat #(
    parameter int IN_W      = 15,
    parameter int OUT_W     = 14,
    parameter int SHIFT_W   = 3,
    parameter int MAX_SHIFT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fft_round_sat_if.slave   bus,
    input  logic             sat_clr,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_cnt
);
    localparam int RW = IN_W + 1;
    typedef logic signed [RW-1:0] rnd_t;

    localparam rnd_t MAXV = rnd_t'((2 ** (OUT_W - 1)) - 1);
    localparam rnd_t MINV = rnd_t'(-(2 ** (OUT_W - 1)));

    // Round one component; the extra MSB makes the half-up add overflow-free.
    function automatic rnd_t round_comp(
        input logic [IN_W-1:0]    x,
        input logic [SHIFT_W-1:0] s,
        input logic [1:0]         m
    );
        rnd_t xe, fl, up, half, mask, rem;
        xe   = {x[IN_W-1], x};
        fl   = xe >>> s;
        up   = fl;
        half = '0;
        mask = '0;
        rem  = '0;
        if (s != '0) begin
            half = rnd_t'(1) << (s - 1'b1);
            mask = (rnd_t'(1) << s) - rnd_t'(1);
            rem  = xe & mask;
            up   = (xe + half) >>> s;
        end
        unique case (m)
            2'b00:   round_comp = fl;
            2'b10:   round_comp = (rem == half && !fl[0]) ? fl : up;
            default: round_comp = up;
        endcase
    endfunction

    // Clamp to the signed output range; MSB of the result flags a clamp.
    function automatic logic [OUT_W:0] sat_comp(input rnd_t v);
        if (v > MAXV)
            sat_comp = {1'b1, MAXV[OUT_W-1:0]};
        else if (v < MINV)
            sat_comp = {1'b1, MINV[OUT_W-1:0]};
        else
            sat_comp = {1'b0, v[OUT_W-1:0]};
    endfunction

    logic               en;
    logic               sat_evt;
    logic [SHIFT_W-1:0] s_clamp;
    logic [OUT_W:0]     sat_re;
    logic [OUT_W:0]     sat_im;

    logic             s1_valid_q, s1_valid_d;
    rnd_t             s1_re_q, s1_re_d;
    rnd_t             s1_im_q, s1_im_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_re_q, out_re_d;
    logic [OUT_W-1:0] out_im_q, out_im_d;
    logic             out_sat_q, out_sat_d;
    logic             sat_sticky_q, sat_sticky_d;

    assign en      = !out_valid_q || bus.out_ready;
    assign sat_evt = out_valid_q && bus.out_ready && out_sat_q;
    assign s_clamp = (bus.shift_i > SHIFT_W'(MAX_SHIFT))
                   ? SHIFT_W'(MAX_SHIFT) : bus.shift_i;
    assign sat_re  = sat_comp(s1_re_q);
    assign sat_im  = sat_comp(s1_im_q);

    // Advance both stages together when the output slot is free or draining.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_re_d     = s1_re_q;
        s1_im_d     = s1_im_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_sat_d   = out_sat_q;
        if (en) begin
            s1_valid_d  = bus.in_valid;
            s1_re_d     = round_comp(bus.in_re, s_clamp, bus.mode_i);
            s1_im_d     = round_comp(bus.in_im, s_clamp, bus.mode_i);
            out_valid_d = s1_valid_q;
            out_re_d    = sat_re[OUT_W-1:0];
            out_im_d    = sat_im[OUT_W-1:0];
            out_sat_d   = sat_re[OUT_W] | sat_im[OUT_W];
        end
    end

    // Sticky saturation flag; a clear in the same cycle beats a new event.
    always_comb begin
        sat_sticky_d = sat_sticky_q;
        if (sat_clr)
            sat_sticky_d = 1'b0;
        else if (sat_evt)
            sat_sticky_d = 1'b1;
    end

    // Pipeline and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_re_q      <= '0;
            s1_im_q      <= '0;
            out_valid_q  <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
            out_sat_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_re_q      <= s1_re_d;
            s1_im_q      <= s1_im_d;
            out_valid_q  <= out_valid_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
            out_sat_q    <= out_sat_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

`ifdef FFT_ROUND_SAT_CNT_EN
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    // Event counter that parks at all-ones instead of wrapping.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (sat_evt && sat_cnt_q != '1)
            sat_cnt_d = sat_cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt_q <= '0;
        else
            sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_sat   = out_sat_q;
    assign sat_sticky    = sat_sticky_q;

endmodule

// File: tb/tb_fft_round_sat.sv
// Scoreboard bench for fft_round_sat: directed corner cases plus a
// randomized stream against an integer-arithmetic reference model.
module tb_fft_round_sat;
    localparam int IN_W = 15, OUT_W = 14, SHIFT_W = 3, MAX_SHIFT = 4, CNT_W = 16;
    localparam int OMAX = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN = -(1 << (OUT_W - 1));
    localparam int CMAX = (1 << CNT_W) - 1;
`ifdef FFT_ROUND_SAT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct { int re; int im; bit sat; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sat_clr = 1'b0;
    logic sat_sticky;
    logic [CNT_W-1:0] sat_cnt;

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    int exp_sticky = 0;
    int exp_cnt = 0;
    bit rand_done = 1'b0;

    fft_round_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

    fft_round_sat #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W),
        .MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .sat_clr(sat_clr),
        .sat_sticky(sat_sticky),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    // Scale by 2^-s with the chosen rounding rule, then clamp.
    function automatic int ref_val(input int x, input int sh, input int m, output bit sat);
        int s, p, q, r, v;
        s = (sh > MAX_SHIFT) ? MAX_SHIFT : sh;
        if (s == 0) begin
            v = x;
        end else begin
            p = 1 << s;
            q = floordiv(x, p);
            r = x - q * p;
            if (m == 0)      v = q;
            else if (m == 2) v = (2 * r > p) ? q + 1 : (2 * r == p) ? q + (q & 1) : q;
            else             v = (2 * r >= p) ? q + 1 : q;
        end
        sat = (v > OMAX) || (v < OMIN);
        if (v > OMAX) v = OMAX;
        if (v < OMIN) v = OMIN;
        return v;
    endfunction

    // Offer one sample at posedge+1 timing and push its expectation once accepted.
    task automatic send(input int re, input int im, input int sh, input int m);
        bit acc, s_re, s_im;
        exp_t e;
        bus.in_re   = IN_W'(re);
        bus.in_im   = IN_W'(im);
        bus.shift_i = SHIFT_W'(sh);
        bus.mode_i  = 2'(m);
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.re  = ref_val(re, sh, m, s_re);
                e.im  = ref_val(im, sh, m, s_im);
                e.sat = s_re | s_im;
                sbq.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sbq.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    // Monitor: compare presented outputs against the queue head and track flags.
    always @(negedge clk) begin
        exp_t e;
        bit sat_x;
        if (rst_n) begin
            chk("in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            chk("sat_sticky", int'(sat_sticky), exp_sticky);
            chk("sat_cnt", int'(sat_cnt), CNT_ON ? exp_cnt : 0);
            sat_x = 1'b0;
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sbq[0];
                    chk("out_re", int'($signed(bus.out_re)), e.re);
                    chk("out_im", int'($signed(bus.out_im)), e.im);
                    chk("out_sat", int'(bus.out_sat), int'(e.sat));
                    if (bus.out_ready) begin
                        void'(sbq.pop_front());
                        sat_x = e.sat;
                    end
                end
            end
            if (sat_clr) begin
                exp_sticky = 0;
                exp_cnt = 0;
            end else if (sat_x) begin
                exp_sticky = 1;
                if (exp_cnt < CMAX) exp_cnt++;
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_re = '0;
        bus.in_im = '0;
        bus.shift_i = '0;
        bus.mode_i = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_re", int'(bus.out_re), 0);
        chk("rst_out_sat", int'(bus.out_sat), 0);
        chk("rst_sticky", int'(sat_sticky), 0);
        chk("rst_cnt", int'(sat_cnt), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Half-up with latency check.
        send(5, -5, 1, 1);
        @(negedge clk);
        chk("lat_cycle1", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_cycle2", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        drain();

        // Convergent and truncate ties.
        send(5, 7, 1, 2);
        send(-5, 0, 1, 2);
        send(-5, 5, 1, 0);
        send(9, -9, 3, 3);
        drain();

        // Saturation at shift 0.
        send(16383, -16384, 0, 1);
        drain();
        chk("t3_sticky", int'(sat_sticky), 1);
        chk("t3_cnt", int'(sat_cnt), CNT_ON ? 1 : 0);

        // Shift clamp.
        send(32, -32, 7, 0);
        send(24, 8, 5, 2);
        drain();

        // Back-to-back with a three-cycle downstream stall.
        fork
            begin
                for (int i = 0; i < 8; i++) send(100 * i - 300, 37 * i, i % 5, i % 4);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Clear coinciding with a saturated transfer.
        sat_clr = 1'b1;
        send(16000, 0, 0, 0);
        drain();
        chk("clr_sticky", int'(sat_sticky), 0);
        chk("clr_cnt", int'(sat_cnt), 0);
        sat_clr = 1'b0;

        // Randomized stream with backpressure and sporadic clears.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(int'($signed(IN_W'($urandom))), int'($signed(IN_W'($urandom))),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    sat_clr = ($urandom_range(0, 19) == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        sat_clr = 1'b0;
        drain();

        // Reset in the middle of a stream.
        send(1, 2, 0, 0);
        send(3, 4, 0, 0);
        #2 rst_n = 1'b0;
        sbq.delete();
        exp_sticky = 0;
        exp_cnt = 0;
        #1;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_sticky", int'(sat_sticky), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_valid", int'(bus.out_valid), 0);
        chk("post_rst_queue", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
